// File: rtl/dna_seq_weight_acc.sv
// dna_seq_weight_acc: streaming DNA digit-weight accumulator.
// Accepts N-digit beats over valid/ready and sums digit weights across a
// sequence. It emits one registered result (score, length, sticky overflow)
// per sequence on a valid/ready output port.
module dna_seq_weight_acc #(
  parameter int N      = 4,
  parameter int SUM_W  = 16,
  parameter int LEN_W  = 16,
  localparam int KEEP_W = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*N-1:0]      in_word,
  input  logic [KEEP_W-1:0]   in_keep,
  input  logic                in_last,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SUM_W-1:0]    out_sum,
  output logic [LEN_W-1:0]    out_len,
  output logic                out_ovf
);

  localparam int BS_W = $clog2(4 * N + 1);
  localparam int SX   = ((SUM_W > BS_W) ? SUM_W : BS_W) + 1;
  localparam int LX   = ((LEN_W > KEEP_W) ? LEN_W : KEEP_W) + 1;

  localparam logic [SX-1:0] SUM_MAX = SX'({SUM_W{1'b1}});
  localparam logic [LX-1:0] LEN_MAX = LX'({LEN_W{1'b1}});

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state;
  logic [SUM_W-1:0]  acc_sum;
  logic [LEN_W-1:0]  acc_len;
  logic              acc_ovf;
  logic              mode_q;

  logic              accept;
  logic              mode_eff;
  logic [KEEP_W-1:0] keep_eff;
  logic [BS_W-1:0]   beat_sum;
  logic [SX-1:0]     sum_ext;
  logic [LX-1:0]     len_ext;
  logic              sum_sat;
  logic              len_sat;
  logic [SUM_W-1:0]  new_sum;
  logic [LEN_W-1:0]  new_len;
  logic              new_ovf;

  assign in_ready  = (state != HOLD) & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == HOLD);

  // Mode comes from the port on the opening beat, from the latch afterwards
  always_comb begin
    mode_eff = (state == IDLE) ? in_mode : mode_q;
    keep_eff = (in_keep > KEEP_W'(N)) ? KEEP_W'(N) : in_keep;
  end

  // Weighted sum of the valid digits in the current beat
  always_comb begin
    logic [1:0] d;
    logic [2:0] w;
    d        = '0;
    w        = '0;
    beat_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      d = in_word[2*i +: 2];
      if (mode_eff)
        w = {2'b00, (d == 2'b01) || (d == 2'b10)};
      else
        w = (d == 2'b00) ? 3'd4 : {1'b0, d};
      if (i < 32'(keep_eff))
        beat_sum = beat_sum + BS_W'(w);
    end
  end

  // Saturating add of the beat onto the open sequence (or onto zero in IDLE)
  always_comb begin
    sum_ext = SX'((state == ACC) ? acc_sum : '0) + SX'(beat_sum);
    len_ext = LX'((state == ACC) ? acc_len : '0) + LX'(keep_eff);
    sum_sat = (sum_ext > SUM_MAX);
    len_sat = (len_ext > LEN_MAX);
    new_sum = sum_sat ? '1 : sum_ext[SUM_W-1:0];
    new_len = len_sat ? '1 : len_ext[LEN_W-1:0];
    new_ovf = ((state == ACC) & acc_ovf) | sum_sat | len_sat;
  end

  // Sequence FSM, accumulator and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc_sum <= '0;
      acc_len <= '0;
      acc_ovf <= 1'b0;
      mode_q  <= 1'b0;
      out_sum <= '0;
      out_len <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            if (state == IDLE)
              mode_q <= in_mode;
            if (in_last) begin
              out_sum <= new_sum;
              out_len <= new_len;
              out_ovf <= new_ovf;
              acc_sum <= '0;
              acc_len <= '0;
              acc_ovf <= 1'b0;
              state   <= HOLD;
            end else begin
              acc_sum <= new_sum;
              acc_len <= new_len;
              acc_ovf <= new_ovf;
              state   <= ACC;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc_sum <= '0;
            acc_len <= '0;
            acc_ovf <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_seq_weight_acc.sv
// Testbench for dna_seq_weight_acc: directed test-plan steps followed by
// random sequences scored by a digit-list reference model.
module tb_dna_seq_weight_acc;

  localparam int N      = 4;
  localparam int SUM_W  = 6;
  localparam int LEN_W  = 6;
  localparam int KEEP_W = 3;
  localparam int SMAX   = 63;
  localparam int LMAX   = 63;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2*N-1:0]    in_word = '0;
  logic [KEEP_W-1:0] in_keep = '0;
  logic              in_last = 1'b0;
  logic              in_mode = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SUM_W-1:0]  out_sum;
  logic [LEN_W-1:0]  out_len;
  logic              out_ovf;

  dna_seq_weight_acc #(.N(N), .SUM_W(SUM_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .in_keep(in_keep), .in_last(in_last), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_len(out_len), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: unbounded totals of the open sequence
  int   m_sum  = 0;
  int   m_len  = 0;
  logic m_open = 1'b0;
  logic m_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int weight(input logic [1:0] d, input logic mode);
    if (mode) return (d == 2'd1 || d == 2'd2) ? 1 : 0;
    return (d == 2'd0) ? 4 : int'(d);
  endfunction

  // Result checks on HOLD entry; hold<0 leaves the result un-acknowledged
  task automatic check_result(input string tag, input int hold);
    int es, el;
    logic eo;
    es = (m_sum > SMAX) ? SMAX : m_sum;
    el = (m_len > LMAX) ? LMAX : m_len;
    eo = (m_sum > SMAX) || (m_len > LMAX);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_sum"},   32'(out_sum),   32'(es));
    chk({tag, "_len"},   32'(out_len),   32'(el));
    chk({tag, "_ovf"},   32'(out_ovf),   32'(eo));
    if (hold < 0) return;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_bp_ready"}, 32'(in_ready),  0);
      chk({tag, "_bp_valid"}, 32'(out_valid), 1);
      chk({tag, "_bp_sum"},   32'(out_sum),   32'(es));
      chk({tag, "_bp_len"},   32'(out_len),   32'(el));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(out_valid), 0);
    chk({tag, "_drop_ready"}, 32'(in_ready),  1);
  endtask

  task automatic send(input logic [7:0] w, input int keep, input logic last,
                      input logic mode, input int gap, input int hold, input string tag);
    bit ok;
    int k;
    repeat (gap) @(posedge clk);
    #1;
    in_word  = w;
    in_keep  = KEEP_W'(keep);
    in_last  = last;
    in_mode  = mode;
    in_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      return;
    end
    if (!m_open) begin
      m_open = 1'b1;
      m_mode = mode;
      m_sum  = 0;
      m_len  = 0;
    end
    k = (keep > N) ? N : keep;
    for (int i = 0; i < k; i++) m_sum += weight(w[2*i +: 2], m_mode);
    m_len += k;
    if (last) begin
      m_open = 1'b0;
      check_result(tag, hold);
    end
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_rst_ready"}, 32'(in_ready),  0);
    chk({tag, "_rst_valid"}, 32'(out_valid), 0);
    chk({tag, "_rst_sum"},   32'(out_sum),   0);
    chk({tag, "_rst_len"},   32'(out_len),   0);
    chk({tag, "_rst_ovf"},   32'(out_ovf),   0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, "_rel_ready"}, 32'(in_ready), 1);
    m_open = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_rel_ready2"}, 32'(in_ready), 1);
  endtask

  initial begin
    do_reset("init");

    // Single beat, both modes
    send(8'b00_01_10_11, 4, 1'b1, 1'b0, 0, 0, "single_m0");
    chk("single_m0_const", 32'(out_sum), 10);
    send(8'b00_01_10_11, 4, 1'b1, 1'b1, 0, 0, "single_m1");
    chk("single_m1_const", 32'(out_sum), 2);

    // Two beats; mode on beat two ignored
    send(8'h00, 4, 1'b0, 1'b0, 0, 0, "two_a");
    send(8'h1B, 2, 1'b1, 1'b1, 0, 0, "two_b");
    chk("two_const_sum", 32'(out_sum), 21);
    chk("two_const_len", 32'(out_len), 6);

    // Same stream with gaps between beats
    send(8'h00, 4, 1'b0, 1'b0, 2, 0, "gap_a");
    send(8'h1B, 2, 1'b1, 1'b0, 3, 0, "gap_b");
    chk("gap_const_sum", 32'(out_sum), 21);

    // Saturation, then a clean sequence
    for (int b = 0; b < 5; b++) send(8'h00, 4, (b == 4), 1'b0, 0, 0, "sat");
    chk("sat_const_sum", 32'(out_sum), 63);
    chk("sat_const_len", 32'(out_len), 20);
    chk("sat_const_ovf", 32'(out_ovf), 1);
    send(8'h00, 1, 1'b1, 1'b0, 0, 0, "post_sat");
    chk("post_sat_sum", 32'(out_sum), 4);
    chk("post_sat_ovf", 32'(out_ovf), 0);

    // Backpressure for three cycles
    send(8'h1B, 4, 1'b1, 1'b0, 0, 3, "bp");

    // Empty sequence and oversized keep
    send(8'hFF, 0, 1'b1, 1'b0, 0, 0, "empty");
    chk("empty_sum", 32'(out_sum), 0);
    chk("empty_len", 32'(out_len), 0);
    send(8'h1B, 7, 1'b1, 1'b0, 0, 0, "keep7");
    chk("keep7_sum", 32'(out_sum), 10);
    chk("keep7_len", 32'(out_len), 4);

    // Reset mid-sequence, then fresh beat
    send(8'h00, 4, 1'b0, 1'b0, 0, 0, "abort_acc");
    do_reset("abort_acc");
    send(8'h1B, 4, 1'b1, 1'b0, 0, 0, "after_abort");
    chk("after_abort_sum", 32'(out_sum), 10);
    chk("after_abort_len", 32'(out_len), 4);

    // Reset while a result is held
    send(8'h1B, 4, 1'b1, 1'b0, 0, -1, "abort_hold");
    do_reset("abort_hold");

    // Random sequences
    for (int s = 0; s < 40; s++) begin
      int nb;
      nb = $urandom_range(1, 20);
      for (int b = 0; b < nb; b++)
        send(8'($urandom), $urandom_range(0, 7), (b == nb - 1), 1'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
